pwm_speed_ctrl: RTL and testbench

Consumer of the 4-bit one-hot speed-level bus (o_lightState) produced by the button-driven mode FSM. Decodes the level into a target duty cycle, ramps the applied duty toward the target in fixed steps for a soft start and soft stop, and generates the motor PWM output. Illegal level codes force an immediate safe stop and raise a fault flag.

---
 rtl/pwm_speed_ctrl.sv | 131 +++++++++++++
 tb/tb_pwm_speed_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_speed_ctrl.sv
// Speed-level to PWM controller: decodes a one-hot level into a target duty,
// ramps the applied duty toward it once per ramp interval, and drives a glitch-free PWM.
module pwm_speed_ctrl #(
  parameter int PERIOD    = 100,
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 5,
  parameter int RAMP_DIV  = 1,
  parameter int DUTY_L1   = 25,
  parameter int DUTY_L2   = 50,
  parameter int DUTY_L3   = 75,
  parameter int DUTY_L4   = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_lightState,
  output logic       o_pwm,
  output logic [7:0] o_duty,
  output logic       o_busy,
  output logic       o_fault
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [7:0] TGT1 = (DUTY_L1 > PERIOD) ? 8'(PERIOD) : 8'(DUTY_L1);
  localparam logic [7:0] TGT2 = (DUTY_L2 > PERIOD) ? 8'(PERIOD) : 8'(DUTY_L2);
  localparam logic [7:0] TGT3 = (DUTY_L3 > PERIOD) ? 8'(PERIOD) : 8'(DUTY_L3);
  localparam logic [7:0] TGT4 = (DUTY_L4 > PERIOD) ? 8'(PERIOD) : 8'(DUTY_L4);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      lvl_q, lvl_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      duty_q, duty_d;
  logic [7:0]      act_q, act_d;
  logic            pwm_q, pwm_d;
  logic            fault_q, fault_d;

  logic [7:0]      target;
  logic            illegal;
  logic            tick, bnd, step_en;
  logic [8:0]      up9, dn_lim9;
  logic [7:0]      duty_step;

  always_comb begin
    lvl_d   = i_lightState;
    target  = 8'd0;
    illegal = 1'b0;
    case (lvl_q)
      4'b0000: target = 8'd0;
      4'b0001: target = TGT1;
      4'b0010: target = TGT2;
      4'b0100: target = TGT3;
      4'b1000: target = TGT4;
      default: illegal = 1'b1;
    endcase

    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    bnd     = tick && (cnt_q == 8'(PERIOD - 1));
    cnt_d   = cnt_q;
    if (tick) cnt_d = bnd ? 8'd0 : cnt_q + 8'd1;
    step_en = bnd && (div_q == DW'(RAMP_DIV - 1));
    div_d   = div_q;
    if (bnd) div_d = step_en ? '0 : div_q + DW'(1);

    // 9-bit sums so the step never wraps before the saturating compare
    up9       = {1'b0, duty_q} + 9'(RAMP_STEP);
    dn_lim9   = {1'b0, target} + 9'(RAMP_STEP);
    duty_step = duty_q;
    case (state_q)
      RAMP_UP:
        if (target > duty_q)
          duty_step = (up9 >= {1'b0, target}) ? target : up9[7:0];
      RAMP_DOWN:
        if (target < duty_q)
          duty_step = ({1'b0, duty_q} <= dn_lim9) ? target : duty_q - 8'(RAMP_STEP);
      default: duty_step = duty_q;
    endcase

    duty_d = step_en ? duty_step : duty_q;
    act_d  = bnd ? duty_d : act_q;

    // direction is re-evaluated every cycle against the post-step duty
    state_d = IDLE;
    if (target > duty_d)      state_d = RAMP_UP;
    else if (target < duty_d) state_d = RAMP_DOWN;

    fault_d = illegal;
    if (illegal) begin
      duty_d  = 8'd0;
      act_d   = 8'd0;
      state_d = IDLE;
    end

    pwm_d = (cnt_q < act_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      lvl_q   <= 4'd0;
      presc_q <= '0;
      cnt_q   <= 8'd0;
      div_q   <= '0;
      duty_q  <= 8'd0;
      act_q   <= 8'd0;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      act_q   <= act_d;
      pwm_q   <= pwm_d;
      fault_q <= fault_d;
    end
  end

  assign o_pwm   = pwm_q;
  assign o_duty  = duty_q;
  assign o_busy  = (state_q != IDLE);
  assign o_fault = fault_q;

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Bench for pwm_speed_ctrl: vector table, corner-case sequences and a
// randomized phase checked against a period-arithmetic reference model.
module tb_pwm_speed_ctrl;

  localparam int P  = 1;
  localparam int PER = 100;
  localparam int RD = 1;
  localparam int STP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lvl;
  logic       pwm, busy, fault;
  logic [7:0] duty;
  logic       pwm2, busy2, fault2;
  logic [7:0] duty2;

  always #5 clk = ~clk;

  pwm_speed_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_lightState(lvl),
    .o_pwm(pwm), .o_duty(duty), .o_busy(busy), .o_fault(fault)
  );

  pwm_speed_ctrl #(.PRESCALE(4), .RAMP_DIV(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_lightState(lvl),
    .o_pwm(pwm2), .o_duty(duty2), .o_busy(busy2), .o_fault(fault2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int tgt_of(input logic [3:0] v);
    case (v)
      4'b0000: return 0;
      4'b0001: return 25;
      4'b0010: return 50;
      4'b0100: return 75;
      4'b1000: return 100;
      default: return -1;
    endcase
  endfunction

  function automatic int m_cnt(input int t);
    return (t / P) % PER;
  endfunction

  function automatic bit m_bnd(input int t);
    return (t % P == P - 1) && (m_cnt(t) == PER - 1);
  endfunction

  function automatic bit m_step(input int t);
    return m_bnd(t) && ((t / (P * PER)) % RD == RD - 1);
  endfunction

  function automatic int m_next(input int t, input int d, input int tg);
    if (!m_step(t)) return d;
    if (tg > d) return (d + STP > tg) ? tg : d + STP;
    if (tg < d) return (d - STP < tg) ? tg : d - STP;
    return d;
  endfunction

  int         m_clk;
  logic [3:0] m_lvl, m_lvl_prev;
  int         m_duty, m_act;
  bit         m_fault, m_pwm;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_clk <= 0; m_lvl <= 4'd0; m_lvl_prev <= 4'd0;
      m_duty <= 0; m_act <= 0; m_fault <= 1'b0; m_pwm <= 1'b0;
    end else begin
      m_pwm      <= (m_cnt(m_clk) < m_act);
      m_lvl      <= lvl;
      m_lvl_prev <= m_lvl;
      m_clk      <= m_clk + 1;
      if (tgt_of(m_lvl) < 0) begin
        m_duty <= 0; m_act <= 0; m_fault <= 1'b1;
      end else begin
        m_fault <= 1'b0;
        m_duty  <= m_next(m_clk, m_duty, tgt_of(m_lvl));
        if (m_bnd(m_clk)) m_act <= m_next(m_clk, m_duty, tgt_of(m_lvl));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pwm", int'(pwm), int'(m_pwm));
      check("model_duty", int'(duty), m_duty);
      check("model_fault", int'(fault), int'(m_fault));
      if (m_lvl == m_lvl_prev)
        check("model_busy", int'(busy),
              int'(tgt_of(m_lvl) >= 0 && m_duty != tgt_of(m_lvl)));
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic wait_duty(input int v, input int maxc, input string name);
    int k;
    k = 0;
    while (int'(duty) != v && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(duty), v);
  endtask

  task automatic count_high(input int ncyc, output int hi);
    hi = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (pwm) hi++;
    end
  endtask

  typedef struct {
    logic [3:0] code;
    int         exp_duty;
    bit         exp_fault;
  } vec_t;

  vec_t tbl[8];
  logic [3:0] legal[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int hi, k, prev, t0, t1;
    int seen[$];

    rst = 1'b1;
    lvl = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    rst = 1'b0;

    // ---- table: steady-state duty, fault and high-tick count per code ----
    tbl[0] = '{4'b0000, 0, 1'b0};
    tbl[1] = '{4'b0001, 25, 1'b0};
    tbl[2] = '{4'b0010, 50, 1'b0};
    tbl[3] = '{4'b0100, 75, 1'b0};
    tbl[4] = '{4'b1000, 100, 1'b0};
    tbl[5] = '{4'b0011, 0, 1'b1};
    tbl[6] = '{4'b1111, 0, 1'b1};
    tbl[7] = '{4'b0101, 0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      lvl = tbl[i].code;
      repeat (2150) @(negedge clk);
      check($sformatf("tbl%0d_duty", i), int'(duty), tbl[i].exp_duty);
      check($sformatf("tbl%0d_fault", i), int'(fault), int'(tbl[i].exp_fault));
      check($sformatf("tbl%0d_busy", i), int'(busy), 0);
      count_high(100, hi);
      check($sformatf("tbl%0d_highs", i), hi, tbl[i].exp_duty);
    end

    // ---- soft start to 25: steps 5..25 one period apart ----
    do_reset();
    lvl = 4'b0001;
    prev = 0; t0 = 0; k = 0;
    seen.delete();
    repeat (700) begin
      @(negedge clk);
      k++;
      if (int'(duty) != prev) begin
        seen.push_back(int'(duty));
        check("t1_busy", int'(busy), int'(duty != 8'd25));
        if (seen.size() > 1) check("t1_interval", k - t0, 100);
        t0 = k;
        prev = int'(duty);
      end
    end
    check("t1_nsteps", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      check($sformatf("t1_step%0d", i), seen[i], 5 * (i + 1));

    // ---- soft stop from 100 ----
    do_reset();
    lvl = 4'b1000;
    repeat (2150) @(negedge clk);
    count_high(100, hi);
    check("t2_full_high", hi, 100);
    lvl = 4'b0000;
    prev = int'(duty); k = 0; t1 = 0;
    while (int'(duty) != 0 && k < 2300) begin
      @(negedge clk);
      k++;
      if (int'(duty) != prev) begin
        check("t2_dec", prev - int'(duty), 5);
        prev = int'(duty);
        t1++;
      end
    end
    check("t2_nsteps", t1, 20);
    repeat (5) @(negedge clk);
    check("t2_busy", int'(busy), 0);
    count_high(200, hi);
    check("t2_low", hi, 0);

    // ---- reversal mid-ramp ----
    do_reset();
    lvl = 4'b0100;
    wait_duty(40, 1000, "t3_reach40");
    lvl = 4'b0001;
    repeat (3) @(negedge clk);
    check("t3_busy_rev", int'(busy), 1);
    prev = int'(duty);
    seen.delete();
    k = 0;
    while (seen.size() < 3 && k < 400) begin
      @(negedge clk);
      k++;
      if (int'(duty) != prev) begin
        seen.push_back(int'(duty));
        prev = int'(duty);
      end
    end
    check("t3_nsteps", seen.size(), 3);
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("t3_step%0d", i), seen[i], 35 - 5 * i);
    repeat (10) @(negedge clk);
    check("t3_idle", int'(busy), 0);

    // ---- illegal code at steady 50, then recovery ----
    do_reset();
    lvl = 4'b0010;
    repeat (1200) @(negedge clk);
    check("t4_steady", int'(duty), 50);
    lvl = 4'b0011;
    @(negedge clk);
    check("t4_fault_e1", int'(fault), 0);
    @(negedge clk);
    check("t4_fault_e2", int'(fault), 1);
    check("t4_duty_e2", int'(duty), 0);
    @(negedge clk);
    check("t4_pwm_e3", int'(pwm), 0);
    count_high(150, hi);
    check("t4_hold_low", hi, 0);
    check("t4_hold_fault", int'(fault), 1);
    check("t4_hold_busy", int'(busy), 0);
    lvl = 4'b0010;
    @(negedge clk);
    check("t4_clr_e1", int'(fault), 1);
    @(negedge clk);
    check("t4_clr_e2", int'(fault), 0);
    prev = 0; k = 0; t1 = 0;
    while (int'(duty) != 50 && k < 1200) begin
      @(negedge clk);
      k++;
      if (int'(duty) != prev) begin
        prev = int'(duty);
        t1++;
      end
    end
    check("t4_ramp_steps", t1, 10);
    check("t4_ramp_end", int'(duty), 50);

    // ---- PRESCALE=4, RAMP_DIV=2 instance ----
    do_reset();
    lvl = 4'b0010;
    prev = 0; k = 0; t0 = -1; t1 = -1;
    while (t1 < 0 && k < 2000) begin
      @(negedge clk);
      k++;
      if (int'(duty2) != prev) begin
        if (t0 < 0) t0 = k; else t1 = k;
        prev = int'(duty2);
      end
    end
    check("t5_step_interval", t1 - t0, 800);
    k = 0;
    while (int'(duty2) != 50 && k < 9000) begin
      @(negedge clk);
      k++;
    end
    check("t5_duty", int'(duty2), 50);
    repeat (900) @(negedge clk);
    k = 0;
    prev = int'(pwm2);
    while (!(prev == 0 && pwm2) && k < 500) begin
      prev = int'(pwm2);
      @(negedge clk);
      k++;
    end
    check("t5_rise_found", int'(k < 500), 1);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (pwm2) hi++;
      if (i == 399) check("t5_end_low", int'(pwm2), 0);
      @(negedge clk);
    end
    check("t5_highs", hi, 200);
    check("t5_next_rise", int'(pwm2), 1);

    // ---- reset mid-period at 75 ----
    do_reset();
    lvl = 4'b0100;
    repeat (1600) @(negedge clk);
    check("t6_steady", int'(duty), 75);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_pwm", int'(pwm), 0);
    check("t6_duty", int'(duty), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_fault", int'(fault), 0);
    check("t6_cnt", int'(dut.cnt_q), 0);
    check("t6_act", int'(dut.act_q), 0);
    rst = 1'b0;
    k = 0;
    while (int'(duty) == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t6_first_step_at", k, 100);
    check("t6_first_step", int'(duty), 5);

    // ---- randomized phase against the model ----
    do_reset();
    chk_en = 1'b1;
    for (int s = 0; s < 30; s++) begin
      while (!((m_clk % PER) >= 5 && (m_clk % PER) <= 80)) @(negedge clk);
      if ($urandom_range(0, 9) < 7) lvl = legal[$urandom_range(0, 4)];
      else lvl = 4'($urandom_range(0, 15));
      repeat ($urandom_range(50, 1000)) @(negedge clk);
    end
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
